// File: rtl/mem_responder.sv
// Single-outstanding load/store responder backed by an internal word array, fixed response latency.
// Optional macro MEM_RESP_ERR_EN: out-of-range addresses raise respErr instead of wrapping.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  input  logic [3:0]  reqWmask,
  output logic        respValid,
  output logic [31:0] respRdata,
  output logic        respErr
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          accept;
  logic          oor;
  logic          mem_we;
  logic          unused_addr_bits;

  assign idx    = reqAddr[AW+1:2];
  assign accept = reqValid && (state_q == S_IDLE);

`ifdef MEM_RESP_ERR_EN
  assign oor              = |reqAddr[31:AW+2];
  assign unused_addr_bits = ^reqAddr[1:0];
`else
  // Upper address bits are dropped so the index wraps around the array.
  assign oor              = 1'b0;
  assign unused_addr_bits = ^{reqAddr[31:AW+2], reqAddr[1:0]};
`endif

  assign mem_we = accept && reqWrite && !oor;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    reqReady  = 1'b0;
    respValid = 1'b0;
    case (state_q)
      S_IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          err_d   = oor;
          rdata_d = (reqWrite || oor) ? 32'h0 : mem[idx];
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        respValid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset: contents survive reset_n, and a committed store is never undone.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (reqWmask[i]) begin
          mem[idx][8*i +: 8] <= reqWdata[8*i +: 8];
        end
      end
    end
  end

  assign respRdata = rdata_q;
  assign respErr   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (latency 1, 2, 5) checked every cycle against a
// transaction-level model, plus directed literal expectations.
module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int NI    = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid [NI];
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        req_ready [NI];
  logic        resp_valid [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 5))
    ) u_dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .reqValid (req_valid[g]),
      .reqReady (req_ready[g]),
      .reqWrite (req_write),
      .reqAddr  (req_addr),
      .reqWdata (req_wdata),
      .reqWmask (req_wmask),
      .respValid(resp_valid[g]),
      .respRdata(resp_rdata[g]),
      .respErr  (resp_err[g])
    );
  end

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int lat_of(int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 5);
  endfunction

  // Model state: expected memory image and the one outstanding transaction per instance.
  logic [31:0] mdl_mem [NI][DEPTH];
  bit          pend [NI];
  int          acc_cyc [NI];
  int          due_cyc [NI];
  logic [31:0] exp_rdata [NI];
  logic        exp_err [NI];

  int          resp_seen_cyc [NI];
  logic [31:0] last_rdata [NI];
  logic        last_err [NI];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    bit in_txn;
    bit exp_v;
    for (int g = 0; g < NI; g++) begin
      in_txn = pend[g] && (cyc >= acc_cyc[g]) && (cyc <= due_cyc[g]);
      exp_v  = pend[g] && (cyc == due_cyc[g]);
      check($sformatf("ready[%0d]", g), {31'h0, req_ready[g]}, {31'h0, !in_txn});
      check($sformatf("valid[%0d]", g), {31'h0, resp_valid[g]}, {31'h0, exp_v});
      if (exp_v && resp_valid[g]) begin
        check($sformatf("rdata[%0d]", g), resp_rdata[g], exp_rdata[g]);
        check($sformatf("err[%0d]", g), {31'h0, resp_err[g]}, {31'h0, exp_err[g]});
        resp_seen_cyc[g] = cyc;
        last_rdata[g]    = resp_rdata[g];
        last_err[g]      = resp_err[g];
      end
    end
  end

  task automatic issue(input int g, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask);
    int idx;
    bit oor;
    @(negedge clock);
    req_valid[g] = 1'b1;
    req_write    = wr;
    req_addr     = addr;
    req_wdata    = wdata;
    req_wmask    = mask;
    @(posedge clock);
    #1;
    req_valid[g] = 1'b0;
`ifdef MEM_RESP_ERR_EN
    oor = (addr >= 32'(DEPTH * 4));
`else
    oor = 1'b0;
`endif
    idx = int'((addr >> 2) % DEPTH);
    exp_err[g]   = oor;
    exp_rdata[g] = (wr || oor) ? 32'h0 : mdl_mem[g][idx];
    if (wr && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) mdl_mem[g][idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    acc_cyc[g] = cyc;
    due_cyc[g] = cyc + lat_of(g) - 1;
    pend[g]    = 1'b1;
  endtask

  task automatic txn(input int g, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] mask);
    issue(g, wr, addr, wdata, mask);
    repeat (lat_of(g)) @(posedge clock);
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      req_valid[g]     = 1'b0;
      pend[g]          = 1'b0;
      resp_seen_cyc[g] = -1;
      last_rdata[g]    = 32'h0;
      last_err[g]      = 1'b0;
    end
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_wmask = 4'h0;

    #1 reset_n = 1'b0;
    @(negedge clock);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rst_rdata[%0d]", g), resp_rdata[g], 32'h0);
      check($sformatf("rst_err[%0d]", g), {31'h0, resp_err[g]}, 32'h0);
    end
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (6) @(posedge clock);

    // Store then load at latency 2.
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    check("st_lat2", resp_seen_cyc[1] - acc_cyc[1] + 1, 32'd2);
    check("st_rdata0", last_rdata[1], 32'h0);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0);
    check("ld_full", last_rdata[1], 32'hDEADBEEF);

    // Partial store, byte offset ignored on the load.
    txn(1, 1'b1, 32'h10, 32'h000000AA, 4'b0001);
    txn(1, 1'b0, 32'h12, 32'hFFFFFFFF, 4'hF);
    check("ld_partial", last_rdata[1], 32'hDEADBEAA);

    // Zero mask store changes nothing.
    txn(1, 1'b1, 32'h10, 32'h12345678, 4'b0000);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0);
    check("ld_mask0", last_rdata[1], 32'hDEADBEAA);

    txn(1, 1'b1, 32'h14, 32'hCAFEF00D, 4'hF);
    txn(1, 1'b1, 32'h14, 32'h11223344, 4'b1010);
    txn(1, 1'b0, 32'h17, 32'h0, 4'h0);
    check("ld_mask1010", last_rdata[1], 32'h11FE330D);

    // Latency sweep.
    for (int g = 0; g < NI; g++) begin
      txn(g, 1'b1, 32'h8, 32'hA5A50000 + 32'(g), 4'hF);
      txn(g, 1'b0, 32'h8, 32'h0, 4'h0);
      check($sformatf("lat_meas[%0d]", g), resp_seen_cyc[g] - acc_cyc[g] + 1,
            (g == 0) ? 32'd1 : ((g == 1) ? 32'd2 : 32'd5));
      check($sformatf("lat_data[%0d]", g), last_rdata[g], 32'hA5A50000 + 32'(g));
    end

    // Out-of-range / wrapping address.
    txn(1, 1'b1, 32'h0, 32'h11223344, 4'hF);
    txn(1, 1'b1, 32'h400, 32'h55667788, 4'hF);
`ifdef MEM_RESP_ERR_EN
    check("oor_err", {31'h0, last_err[1]}, 32'd1);
`else
    check("oor_err", {31'h0, last_err[1]}, 32'd0);
`endif
    txn(1, 1'b0, 32'h0, 32'h0, 4'h0);
`ifdef MEM_RESP_ERR_EN
    check("oor_word0", last_rdata[1], 32'h11223344);
`else
    check("oor_word0", last_rdata[1], 32'h55667788);
`endif

    // Protocol violation during WAIT is ignored.
    txn(2, 1'b1, 32'h20, 32'h0BADF00D, 4'hF);
    issue(2, 1'b0, 32'h20, 32'h0, 4'h0);
    @(negedge clock);
    req_valid[2] = 1'b1;
    req_write    = 1'b1;
    req_addr     = 32'h20;
    req_wdata    = 32'hFFFFFFFF;
    req_wmask    = 4'hF;
    @(posedge clock);
    #1 req_valid[2] = 1'b0;
    repeat (4) @(posedge clock);
    check("viol_resp", last_rdata[2], 32'h0BADF00D);
    repeat (3) @(posedge clock);
    txn(2, 1'b0, 32'h20, 32'h0, 4'h0);
    check("viol_mem", last_rdata[2], 32'h0BADF00D);

    // Reset pulsed during WAIT of a load drops the response.
    issue(2, 1'b0, 32'h20, 32'h0, 4'h0);
    @(posedge clock);
    #1 reset_n = 1'b0;
    for (int g = 0; g < NI; g++) pend[g] = 1'b0;
    @(negedge clock);
    check("midrst_rdata", resp_rdata[2], 32'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clock);
    txn(2, 1'b0, 32'h20, 32'h0, 4'h0);
    check("post_rst_ld", last_rdata[2], 32'h0BADF00D);

    repeat (4) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
